// File: rtl/frame_min_max_stats.sv
// rtl/frame_min_max_stats.sv - per-frame running min/max of qualified pixels, published at fval fall
module frame_min_max_stats #(
    parameter int DATA_WIDTH = 13,
    parameter int CNT_WIDTH  = 12,
    parameter int H_SKIP     = 0,
    parameter int V_SKIP     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stats_en,
    input  logic                  lval_in,
    input  logic                  fval_in,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  lval_out,
    output logic                  fval_out,
    output logic [DATA_WIDTH-1:0] min_val,
    output logic [DATA_WIDTH-1:0] max_val,
    output logic                  stats_valid,
    output logic                  stats_empty
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] H_SKIP_C = CNT_WIDTH'(H_SKIP);
    localparam logic [CNT_WIDTH-1:0] V_SKIP_C = CNT_WIDTH'(V_SKIP);

    logic                  fval_q, lval_q;
    logic                  armed_q, armed_d;
    logic                  any_q, any_d;
    logic [DATA_WIDTH-1:0] acc_min_q, acc_min_d;
    logic [DATA_WIDTH-1:0] acc_max_q, acc_max_d;
    logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
    logic [DATA_WIDTH-1:0] min_val_d, max_val_d;
    logic                  stats_valid_d, stats_empty_d;
    logic [DATA_WIDTH-1:0] data_p_q;
    logic                  lval_p_q, fval_p_q;

    logic                  fval_rise, fval_fall, lval_rise, lval_fall;
    logic                  armed_eff, any_base, qual, h_ok, v_ok;
    logic [CNT_WIDTH-1:0]  pix_idx, line_idx;
    logic [DATA_WIDTH-1:0] acc_min_base, acc_max_base;

    assign fval_rise = fval_in & ~fval_q;
    assign fval_fall = ~fval_in & fval_q;
    assign lval_rise = lval_in & ~lval_q;
    assign lval_fall = ~lval_in & lval_q;

    // A rise re-initialises state in the same cycle, so a pixel arriving with the rise
    // is already judged against the new frame's arm/counters/accumulators.
    assign armed_eff    = fval_rise ? stats_en : armed_q;
    assign pix_idx      = lval_rise ? '0 : pix_cnt_q;
    assign line_idx     = fval_rise ? '0 : line_cnt_q;
    assign acc_min_base = fval_rise ? '1 : acc_min_q;
    assign acc_max_base = fval_rise ? '0 : acc_max_q;
    assign any_base     = fval_rise ? 1'b0 : any_q;

    generate
        if (H_SKIP == 0) begin : g_h_all
            assign h_ok = 1'b1;
        end else begin : g_h_skip
            assign h_ok = (pix_idx >= H_SKIP_C);
        end
        if (V_SKIP == 0) begin : g_v_all
            assign v_ok = 1'b1;
        end else begin : g_v_skip
            assign v_ok = (line_idx >= V_SKIP_C);
        end
    endgenerate

    assign qual = fval_in & lval_in & armed_eff & h_ok & v_ok;

    always_comb begin
        armed_d       = armed_eff;
        any_d         = any_base | qual;
        acc_min_d     = acc_min_base;
        acc_max_d     = acc_max_base;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_idx;
        min_val_d     = min_val;
        max_val_d     = max_val;
        stats_valid_d = 1'b0;
        stats_empty_d = stats_empty;

        if (qual && (data < acc_min_base)) acc_min_d = data;
        if (qual && (data > acc_max_base)) acc_max_d = data;

        if (lval_in) pix_cnt_d = (pix_idx == CNT_MAX) ? CNT_MAX : pix_idx + CNT_WIDTH'(1);
        if (lval_fall && fval_in && (line_idx != CNT_MAX)) line_cnt_d = line_idx + CNT_WIDTH'(1);

        if (fval_fall && armed_q) begin
            stats_valid_d = 1'b1;
            stats_empty_d = ~any_q;
            if (any_q) begin
                min_val_d = acc_min_q;
                max_val_d = acc_max_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // fval history resets high so a frame already in flight is not mistaken for a new one
            fval_q      <= 1'b1;
            lval_q      <= 1'b0;
            armed_q     <= 1'b0;
            any_q       <= 1'b0;
            acc_min_q   <= '1;
            acc_max_q   <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            min_val     <= '0;
            max_val     <= '1;
            stats_valid <= 1'b0;
            stats_empty <= 1'b0;
            data_p_q    <= '0;
            lval_p_q    <= 1'b0;
            fval_p_q    <= 1'b0;
            data_out    <= '0;
            lval_out    <= 1'b0;
            fval_out    <= 1'b0;
        end else begin
            fval_q      <= fval_in;
            lval_q      <= lval_in;
            armed_q     <= armed_d;
            any_q       <= any_d;
            acc_min_q   <= acc_min_d;
            acc_max_q   <= acc_max_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            min_val     <= min_val_d;
            max_val     <= max_val_d;
            stats_valid <= stats_valid_d;
            stats_empty <= stats_empty_d;
            data_p_q    <= data;
            lval_p_q    <= lval_in;
            fval_p_q    <= fval_in;
            data_out    <= data_p_q;
            lval_out    <= lval_p_q;
            fval_out    <= fval_p_q;
        end
    end

endmodule

// File: tb/tb_frame_min_max_stats.sv
// tb/tb_frame_min_max_stats.sv - scoreboard bench for frame_min_max_stats (no-skip and 1/1-skip instances)
module tb_frame_min_max_stats;

    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stats_en = 1'b0;
    logic          lval_in = 1'b0;
    logic          fval_in = 1'b0;
    logic [DW-1:0] data = '0;

    logic [DW-1:0] s0_dout, s0_min, s0_max, s1_dout, s1_min, s1_max;
    logic          s0_lout, s0_fout, s0_valid, s0_empty;
    logic          s1_lout, s1_fout, s1_valid, s1_empty;

    always #5 clk = ~clk;

    frame_min_max_stats #(.DATA_WIDTH(DW), .CNT_WIDTH(12), .H_SKIP(0), .V_SKIP(0)) dut0 (
        .clk(clk), .rst(rst), .stats_en(stats_en), .lval_in(lval_in), .fval_in(fval_in),
        .data(data), .data_out(s0_dout), .lval_out(s0_lout), .fval_out(s0_fout),
        .min_val(s0_min), .max_val(s0_max), .stats_valid(s0_valid), .stats_empty(s0_empty));

    frame_min_max_stats #(.DATA_WIDTH(DW), .CNT_WIDTH(12), .H_SKIP(1), .V_SKIP(1)) dut1 (
        .clk(clk), .rst(rst), .stats_en(stats_en), .lval_in(lval_in), .fval_in(fval_in),
        .data(data), .data_out(s1_dout), .lval_out(s1_lout), .fval_out(s1_fout),
        .min_val(s1_min), .max_val(s1_max), .stats_valid(s1_valid), .stats_empty(s1_empty));

    typedef struct packed {
        logic          empty;
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW+1:0] h1 = '0;
    logic [DW+1:0] h2 = '0;
    bit            chk_pass = 1'b0;
    logic [DW-1:0] mdl_min[2];
    logic [DW-1:0] mdl_max[2];
    logic [DW-1:0] pixbuf[64];

    function automatic logic [DW-1:0] pix(input int mode, input int x, input int y, input int w);
        int i;
        i = y * w + x;
        case (mode)
            0: return DW'(100 + i);
            1: begin
                if (y == 0) return (x == 0) ? DW'(0) : DW'(8191);
                if (x == 0) return DW'(0);
                return DW'(50 + (y - 1) * 3 + (x - 1));
            end
            2: return DW'(10 + i % 11);
            3: return (i == 5) ? DW'(400) : DW'(300 + (i * 37) % 100);
            default: return DW'($urandom);
        endcase
    endfunction

    // One clock: record inputs seen at the edge, then check pulses and pass-through #1 later
    task automatic step();
        exp_t e;
        @(posedge clk);
        h2 = h1;
        h1 = {data, lval_in, fval_in};
        #1;
        if (!rst) begin
            if (s0_valid) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse0 got stats_valid=1 expected 0");
                end else begin
                    e = q0.pop_front();
                    if ({s0_empty, s0_min, s0_max} !== e)
                        begin n_err++; $display("FAIL stats0 got empty=%0b min=%0d max=%0d expected empty=%0b min=%0d max=%0d",
                            s0_empty, s0_min, s0_max, e.empty, e.mn, e.mx); end
                end
            end
            if (s1_valid) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse1 got stats_valid=1 expected 0");
                end else begin
                    e = q1.pop_front();
                    if ({s1_empty, s1_min, s1_max} !== e)
                        begin n_err++; $display("FAIL stats1 got empty=%0b min=%0d max=%0d expected empty=%0b min=%0d max=%0d",
                            s1_empty, s1_min, s1_max, e.empty, e.mn, e.mx); end
                end
            end
            if (chk_pass) begin
                n_cmp++;
                if ({s0_dout, s0_lout, s0_fout} !== h2) begin
                    n_err++;
                    $display("FAIL pass_through got %h expected %h", {s0_dout, s0_lout, s0_fout}, h2);
                end
            end
        end
    endtask

    task automatic send_frame(input logic en, input int w, input int h, input int mode,
                              input bit toggle_en, input bit tight);
        logic [DW-1:0] mn, mx;
        bit            any;
        for (int i = 0; i < w * h; i++) pixbuf[i] = pix(mode, i % w, i / w, w);
        for (int k = 0; k < 2; k++) begin
            any = 1'b0; mn = '1; mx = '0;
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++)
                    if (x >= k && y >= k) begin
                        any = 1'b1;
                        if (pixbuf[y * w + x] < mn) mn = pixbuf[y * w + x];
                        if (pixbuf[y * w + x] > mx) mx = pixbuf[y * w + x];
                    end
            if (en) begin
                if (any) begin mdl_min[k] = mn; mdl_max[k] = mx; end
                if (k == 0) q0.push_back({~any, mdl_min[k], mdl_max[k]});
                else        q1.push_back({~any, mdl_min[k], mdl_max[k]});
            end
        end
        fval_in = 1'b1; stats_en = en; lval_in = 1'b0;
        step();
        stats_en = toggle_en ? ~en : en;
        step();
        for (int y = 0; y < h; y++) begin
            if (w > 0) begin
                lval_in = 1'b1;
                for (int x = 0; x < w; x++) begin
                    data = pixbuf[y * w + x];
                    if (toggle_en) stats_en = 1'($urandom);
                    step();
                end
            end
            if (!(tight && y == h - 1)) begin
                lval_in = 1'b0; data = DW'($urandom);
                step(); step();
            end
        end
        fval_in = 1'b0; lval_in = 1'b0; stats_en = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++; if ({s0_dout, s0_lout, s0_fout} !== '0) begin n_err++; $display("FAIL reset_pipe got %h expected 0", {s0_dout, s0_lout, s0_fout}); end
        n_cmp++; if (s0_min !== '0) begin n_err++; $display("FAIL reset_min got %0d expected 0", s0_min); end
        n_cmp++; if (s0_max !== 13'h1fff) begin n_err++; $display("FAIL reset_max got %0d expected 8191", s0_max); end
        n_cmp++; if ({s0_valid, s0_empty} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b expected 00", {s0_valid, s0_empty}); end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin mdl_min[k] = '0; mdl_max[k] = '1; end
        step(); step();
        chk_pass = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_frame(1'b1, 4, 4, 0, 1'b0, 1'b0);
        n_cmp++; if (s0_valid !== 1'b1) begin n_err++; $display("FAIL valid_t1 got %b expected 1", s0_valid); end
        n_cmp++; if (s0_fout !== 1'b1) begin n_err++; $display("FAIL fval_out_t1 got %b expected 1", s0_fout); end
        step();
        n_cmp++; if (s0_valid !== 1'b0) begin n_err++; $display("FAIL valid_t2 got %b expected 0", s0_valid); end
        n_cmp++; if (s0_fout !== 1'b0) begin n_err++; $display("FAIL fval_out_t2 got %b expected 0", s0_fout); end
        n_cmp++; if ({s0_min, s0_max} !== {13'd100, 13'd115}) begin n_err++; $display("FAIL basic_hold got %0d/%0d expected 100/115", s0_min, s0_max); end
        repeat (3) step();
    endtask

    task automatic test_empty();
        send_frame(1'b1, 0, 3, 0, 1'b0, 1'b0);
        repeat (3) step();
    endtask

    task automatic test_skip();
        send_frame(1'b1, 4, 4, 1, 1'b0, 1'b0);
        repeat (3) step();
        n_cmp++; if ({s1_min, s1_max} !== {13'd50, 13'd58}) begin n_err++; $display("FAIL skip_range got %0d/%0d expected 50/58", s1_min, s1_max); end
    endtask

    task automatic test_reset_mid();
        chk_pass = 1'b0;
        fval_in = 1'b1; stats_en = 1'b1; lval_in = 1'b0;
        step(); step();
        lval_in = 1'b1;
        for (int x = 0; x < 4; x++) begin data = DW'(1 + x); step(); end
        lval_in = 1'b0; step(); step();
        lval_in = 1'b1; data = DW'(2); step(); step();
        rst = 1'b1; step();
        n_cmp++; if ({s0_min, s0_max} !== {13'd0, 13'h1fff}) begin n_err++; $display("FAIL midreset_minmax got %0d/%0d expected 0/8191", s0_min, s0_max); end
        n_cmp++; if ({s0_dout, s0_lout, s0_fout, s0_valid, s0_empty} !== '0) begin n_err++; $display("FAIL midreset_outs got %h expected 0", {s0_dout, s0_lout, s0_fout, s0_valid, s0_empty}); end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin mdl_min[k] = '0; mdl_max[k] = '1; end
        data = DW'(3); step(); step();
        lval_in = 1'b0; step(); step();
        lval_in = 1'b1;
        for (int x = 0; x < 4; x++) begin data = DW'(5 + x); step(); end
        lval_in = 1'b0; step();
        fval_in = 1'b0; stats_en = 1'b0;
        repeat (4) step();
        n_cmp++; if ({s0_min, s0_max} !== {13'd0, 13'h1fff}) begin n_err++; $display("FAIL midreset_ignored got %0d/%0d expected 0/8191", s0_min, s0_max); end
        chk_pass = 1'b1;
        send_frame(1'b1, 4, 4, 0, 1'b0, 1'b0);
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        send_frame(1'b1, 4, 4, 2, 1'b0, 1'b1);
        send_frame(1'b1, 4, 4, 3, 1'b0, 1'b0);
        repeat (3) step();
        n_cmp++; if ({s0_min, s0_max} !== {13'd300, 13'd400}) begin n_err++; $display("FAIL b2b_final got %0d/%0d expected 300/400", s0_min, s0_max); end
    endtask

    task automatic test_disabled();
        send_frame(1'b0, 4, 4, 4, 1'b1, 1'b0);
        repeat (4) step();
        n_cmp++; if ({s0_min, s0_max} !== {mdl_min[0], mdl_max[0]}) begin n_err++; $display("FAIL disabled_hold0 got %0d/%0d expected %0d/%0d", s0_min, s0_max, mdl_min[0], mdl_max[0]); end
        n_cmp++; if ({s1_min, s1_max} !== {mdl_min[1], mdl_max[1]}) begin n_err++; $display("FAIL disabled_hold1 got %0d/%0d expected %0d/%0d", s1_min, s1_max, mdl_min[1], mdl_max[1]); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            send_frame(1'b1, 1 + int'($urandom_range(7)), 1 + int'($urandom_range(7)), 4, 1'b0, f[0]);
            repeat (int'($urandom_range(2))) step();
        end
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_skip();
        test_reset_mid();
        test_back_to_back();
        test_disabled();
        test_random();
        n_cmp++; if (q0.size() != 0) begin n_err++; $display("FAIL pending0 got %0d left expected 0", q0.size()); end
        n_cmp++; if (q1.size() != 0) begin n_err++; $display("FAIL pending1 got %0d left expected 0", q1.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
